uparc_memu: RTL and testbench

- Memory-stage load/store unit of the uparc pipeline. It sits between execute (p2) and writeback (p3).
- Takes execute-stage results and memory ops, runs single-beat bus transactions, and produces destination register number/data for writeback.
- It is the producer side of operand forwarding: it drives the p3 destination/data pair and the pending-load indication consumed by decode forwarding.
- Stalls upstream while a bus transaction is outstanding.

---
 rtl/uparc_memu.sv | 203 ++++++++++++++++++++
 tb/tb_uparc_memu.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uparc_memu.sv
// Memory-stage load/store unit: registers ALU results, runs single-beat bus
// transactions for loads/stores and presents the p3 destination pair for forwarding.
module uparc_memu #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int REGNO_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [1:0]             i_op,
    input  logic [1:0]             i_size,
    input  logic                   i_sext,
    input  logic [REGNO_WIDTH-1:0] i_rd,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0]  i_data,
    output logic                   o_stall,
    output logic                   o_pend_load,
    output logic [REGNO_WIDTH-1:0] o_rd,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    output logic                   o_addr_err,
    output logic [1:0]             o_bus_cmd,
    output logic [ADDR_WIDTH-1:0]  o_bus_addr,
    output logic [DATA_WIDTH-1:0]  o_bus_data,
    output logic [3:0]             o_bus_be,
    input  logic                   i_bus_rdy,
    input  logic [DATA_WIDTH-1:0]  i_bus_data
);
    typedef enum logic { IDLE, BUSY } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;

    state_t                 state, state_n;
    logic                   r_load, r_load_n;
    logic [1:0]             r_size, r_size_n;
    logic [1:0]             r_off, r_off_n;
    logic                   r_sext, r_sext_n;
    logic [REGNO_WIDTH-1:0] r_rd, r_rd_n;
    // One-entry holding slot for an ALU result accepted while the output
    // register is already claimed by a load completion.
    logic                   skid_valid, skid_valid_n;
    logic [REGNO_WIDTH-1:0] skid_rd, skid_rd_n;
    logic [DATA_WIDTH-1:0]  skid_data, skid_data_n;

    logic [REGNO_WIDTH-1:0] rd_n;
    logic [DATA_WIDTH-1:0]  rd_data_n;
    logic                   addr_err_n;
    logic [1:0]             cmd_n;
    logic [ADDR_WIDTH-1:0]  baddr_n;
    logic [DATA_WIDTH-1:0]  bdata_n;
    logic [3:0]             be_n;

    logic                   is_mem, aligned, accept, complete, out_used;
    logic [7:0]             lane_b;
    logic [15:0]            lane_h;
    logic [DATA_WIDTH-1:0]  load_value;

    assign is_mem   = (i_op == OP_LOAD) || (i_op == OP_STORE);
    assign accept   = i_valid && ((state == IDLE) || i_bus_rdy);
    assign complete = (state == BUSY) && i_bus_rdy;

    assign o_stall     = (state == BUSY) && !i_bus_rdy;
    assign o_pend_load = (state == BUSY) && r_load;

    always_comb begin
        unique case (i_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !i_addr[0];
            default: aligned = (i_addr[1:0] == 2'b00);
        endcase
    end

    // Big-endian lanes: offset 0 is bits 31:24.
    always_comb begin
        unique case (r_off)
            2'd0:    lane_b = i_bus_data[31:24];
            2'd1:    lane_b = i_bus_data[23:16];
            2'd2:    lane_b = i_bus_data[15:8];
            default: lane_b = i_bus_data[7:0];
        endcase
        lane_h = r_off[1] ? i_bus_data[15:0] : i_bus_data[31:16];
        unique case (r_size)
            2'b00:   load_value = {{(DATA_WIDTH-8){r_sext & lane_b[7]}}, lane_b};
            2'b01:   load_value = {{(DATA_WIDTH-16){r_sext & lane_h[15]}}, lane_h};
            default: load_value = i_bus_data;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave one unassigned and infer a latch.
        state_n      = state;
        r_load_n     = r_load;
        r_size_n     = r_size;
        r_off_n      = r_off;
        r_sext_n     = r_sext;
        r_rd_n       = r_rd;
        skid_valid_n = skid_valid;
        skid_rd_n    = skid_rd;
        skid_data_n  = skid_data;
        rd_n         = '0;
        rd_data_n    = '0;
        addr_err_n   = 1'b0;
        cmd_n        = o_bus_cmd;
        baddr_n      = o_bus_addr;
        bdata_n      = o_bus_data;
        be_n         = o_bus_be;
        out_used     = 1'b0;

        if (complete) begin
            state_n = IDLE;
            cmd_n   = CMD_IDLE;
            if (r_load && (r_rd != '0)) begin
                rd_n      = r_rd;
                rd_data_n = load_value;
                out_used  = 1'b1;
            end
        end else if (state == IDLE && skid_valid && !(accept && is_mem && !aligned)) begin
            rd_n         = skid_rd;
            rd_data_n    = skid_data;
            skid_valid_n = 1'b0;
            out_used     = 1'b1;
        end

        if (accept) begin
            if (is_mem && !aligned) begin
                addr_err_n = 1'b1;
            end else if (is_mem) begin
                state_n  = BUSY;
                r_load_n = (i_op == OP_LOAD);
                r_size_n = i_size;
                r_off_n  = i_addr[1:0];
                r_sext_n = i_sext;
                r_rd_n   = i_rd;
                cmd_n    = (i_op == OP_LOAD) ? CMD_RD : CMD_WR;
                baddr_n  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                unique case (i_size)
                    2'b00: begin
                        be_n    = 4'b1000 >> i_addr[1:0];
                        bdata_n = {4{i_data[7:0]}};
                    end
                    2'b01: begin
                        be_n    = i_addr[1] ? 4'b0011 : 4'b1100;
                        bdata_n = {2{i_data[15:0]}};
                    end
                    default: begin
                        be_n    = 4'b1111;
                        bdata_n = i_data;
                    end
                endcase
            end else if (out_used) begin
                skid_valid_n = 1'b1;
                skid_rd_n    = i_rd;
                skid_data_n  = i_data;
            end else begin
                rd_n      = i_rd;
                rd_data_n = i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            r_load     <= 1'b0;
            r_size     <= '0;
            r_off      <= '0;
            r_sext     <= 1'b0;
            r_rd       <= '0;
            skid_valid <= 1'b0;
            skid_rd    <= '0;
            skid_data  <= '0;
            o_rd       <= '0;
            o_rd_data  <= '0;
            o_addr_err <= 1'b0;
            o_bus_cmd  <= CMD_IDLE;
            o_bus_addr <= '0;
            o_bus_data <= '0;
            o_bus_be   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state      <= state_n;
            r_load     <= r_load_n;
            r_size     <= r_size_n;
            r_off      <= r_off_n;
            r_sext     <= r_sext_n;
            r_rd       <= r_rd_n;
            skid_valid <= skid_valid_n;
            skid_rd    <= skid_rd_n;
            skid_data  <= skid_data_n;
            o_rd       <= rd_n;
            o_rd_data  <= rd_data_n;
            o_addr_err <= addr_err_n;
            o_bus_cmd  <= cmd_n;
            o_bus_addr <= baddr_n;
            o_bus_data <= bdata_n;
            o_bus_be   <= be_n;
        end
    end
endmodule

// File: tb/tb_uparc_memu.sv
// Directed bench for uparc_memu: hand-computed vectors covering loads, stores,
// misalignment, back-to-back completion and reset while busy.
module tb_uparc_memu;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [1:0]  i_op;
    logic [1:0]  i_size;
    logic        i_sext;
    logic [4:0]  i_rd;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_stall;
    logic        o_pend_load;
    logic [4:0]  o_rd;
    logic [31:0] o_rd_data;
    logic        o_addr_err;
    logic [1:0]  o_bus_cmd;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_data;
    logic [3:0]  o_bus_be;
    logic        i_bus_rdy;
    logic [31:0] i_bus_data;

    int passed = 0;
    int total  = 0;

    uparc_memu dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_op(i_op), .i_size(i_size),
        .i_sext(i_sext), .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data),
        .o_stall(o_stall), .o_pend_load(o_pend_load), .o_rd(o_rd),
        .o_rd_data(o_rd_data), .o_addr_err(o_addr_err), .o_bus_cmd(o_bus_cmd),
        .o_bus_addr(o_bus_addr), .o_bus_data(o_bus_data), .o_bus_be(o_bus_be),
        .i_bus_rdy(i_bus_rdy), .i_bus_data(i_bus_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic sext,
                         input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data);
        i_valid = 1'b1;
        i_op    = op;
        i_size  = size;
        i_sext  = sext;
        i_rd    = rd;
        i_addr  = addr;
        i_data  = data;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_op = 2'b00; i_size = 2'b00; i_sext = 1'b0;
        i_rd = '0; i_addr = '0; i_data = '0; i_bus_rdy = 1'b0; i_bus_data = '0;
        #1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_rd", 32'(o_rd), 32'd0);
        check("reset_cmd", 32'(o_bus_cmd), 32'd0);
        check("reset_be", 32'(o_bus_be), 32'd0);
        check("reset_stall", 32'(o_stall), 32'd0);
        check("reset_pend", 32'(o_pend_load), 32'd0);
        check("reset_err", 32'(o_addr_err), 32'd0);

        // Word load, two wait cycles.
        issue(2'b01, 2'b10, 1'b0, 5'd5, 32'h100, 32'h0);
        tick();
        i_valid = 1'b0;
        #1;
        check("wl_cmd", 32'(o_bus_cmd), 32'd1);
        check("wl_addr", o_bus_addr, 32'h100);
        check("wl_be", 32'(o_bus_be), 32'hF);
        check("wl_stall1", 32'(o_stall), 32'd1);
        check("wl_pend1", 32'(o_pend_load), 32'd1);
        check("wl_rd_busy", 32'(o_rd), 32'd0);
        tick();
        check("wl_stall2", 32'(o_stall), 32'd1);
        check("wl_pend2", 32'(o_pend_load), 32'd1);
        check("wl_cmd_held", 32'(o_bus_cmd), 32'd1);
        i_bus_rdy = 1'b1; i_bus_data = 32'hDEADBEEF;
        #1;
        check("wl_stall_rdy", 32'(o_stall), 32'd0);
        tick();
        i_bus_rdy = 1'b0;
        check("wl_rd", 32'(o_rd), 32'd5);
        check("wl_data", o_rd_data, 32'hDEADBEEF);
        check("wl_cmd_done", 32'(o_bus_cmd), 32'd0);
        check("wl_pend_done", 32'(o_pend_load), 32'd0);

        // Signed byte load at offset 1.
        issue(2'b01, 2'b00, 1'b1, 5'd7, 32'h101, 32'h0);
        tick();
        i_valid = 1'b0;
        check("sb_be", 32'(o_bus_be), 32'b0100);
        check("sb_addr", o_bus_addr, 32'h100);
        i_bus_rdy = 1'b1; i_bus_data = 32'h12F45678;
        tick();
        i_bus_rdy = 1'b0;
        check("sb_rd", 32'(o_rd), 32'd7);
        check("sb_data", o_rd_data, 32'hFFFFFFF4);

        // Same byte load, zero-extended.
        issue(2'b01, 2'b00, 1'b0, 5'd7, 32'h101, 32'h0);
        tick();
        i_valid = 1'b0;
        i_bus_rdy = 1'b1;
        tick();
        i_bus_rdy = 1'b0;
        check("ub_data", o_rd_data, 32'h000000F4);

        // Signed halfword load at offset 2 (lower half 0x5678 is positive).
        issue(2'b01, 2'b01, 1'b1, 5'd8, 32'h202, 32'h0);
        tick();
        i_valid = 1'b0;
        check("sh_be", 32'(o_bus_be), 32'b0011);
        i_bus_rdy = 1'b1; i_bus_data = 32'h8000_5678;
        tick();
        i_bus_rdy = 1'b0;
        check("sh_data", o_rd_data, 32'h00005678);

        // Halfword store, ready immediately.
        issue(2'b10, 2'b01, 1'b0, 5'd0, 32'h102, 32'h0000ABCD);
        #1;
        check("st_stall_acc", 32'(o_stall), 32'd0);
        tick();
        i_valid = 1'b0;
        i_bus_rdy = 1'b1;
        #1;
        check("st_cmd", 32'(o_bus_cmd), 32'd2);
        check("st_addr", o_bus_addr, 32'h100);
        check("st_be", 32'(o_bus_be), 32'b0011);
        check("st_bdata", o_bus_data, 32'hABCDABCD);
        check("st_stall", 32'(o_stall), 32'd0);
        check("st_pend", 32'(o_pend_load), 32'd0);
        tick();
        i_bus_rdy = 1'b0;
        check("st_cmd_done", 32'(o_bus_cmd), 32'd0);
        check("st_rd", 32'(o_rd), 32'd0);

        // Byte store replicates the low byte.
        issue(2'b10, 2'b00, 1'b0, 5'd0, 32'h403, 32'h000000A5);
        tick();
        i_valid = 1'b0;
        check("sbst_be", 32'(o_bus_be), 32'b0001);
        check("sbst_bdata", o_bus_data, 32'hA5A5A5A5);
        i_bus_rdy = 1'b1;
        tick();
        i_bus_rdy = 1'b0;

        // Misaligned word load.
        issue(2'b01, 2'b10, 1'b0, 5'd4, 32'h102, 32'h0);
        tick();
        i_valid = 1'b0;
        check("mis_err", 32'(o_addr_err), 32'd1);
        check("mis_cmd", 32'(o_bus_cmd), 32'd0);
        check("mis_rd", 32'(o_rd), 32'd0);
        check("mis_stall", 32'(o_stall), 32'd0);
        tick();
        check("mis_err_pulse", 32'(o_addr_err), 32'd0);

        // ALU op, latency one.
        issue(2'b00, 2'b00, 1'b0, 5'd12, 32'h0, 32'h0000CAFE);
        tick();
        i_valid = 1'b0;
        check("alu_rd", 32'(o_rd), 32'd12);
        check("alu_data", o_rd_data, 32'h0000CAFE);
        tick();
        check("idle_rd", 32'(o_rd), 32'd0);

        // Load to r0: bus cycle happens, nothing forwarded.
        issue(2'b01, 2'b10, 1'b0, 5'd0, 32'h500, 32'h0);
        tick();
        i_valid = 1'b0;
        check("r0_cmd", 32'(o_bus_cmd), 32'd1);
        i_bus_rdy = 1'b1; i_bus_data = 32'h55555555;
        tick();
        i_bus_rdy = 1'b0;
        check("r0_rd", 32'(o_rd), 32'd0);
        check("r0_data", o_rd_data, 32'd0);

        // Load completion with an ALU op presented in the ready cycle.
        issue(2'b01, 2'b10, 1'b0, 5'd9, 32'h200, 32'h0);
        tick();
        issue(2'b00, 2'b00, 1'b0, 5'd3, 32'h0, 32'd7);
        i_bus_rdy = 1'b1; i_bus_data = 32'h11223344;
        tick();
        i_valid = 1'b0; i_bus_rdy = 1'b0;
        check("b2b_ld_rd", 32'(o_rd), 32'd9);
        check("b2b_ld_data", o_rd_data, 32'h11223344);
        tick();
        check("b2b_alu_rd", 32'(o_rd), 32'd3);
        check("b2b_alu_data", o_rd_data, 32'd7);
        tick();
        check("b2b_idle_rd", 32'(o_rd), 32'd0);

        // Reset while a load is outstanding.
        issue(2'b01, 2'b10, 1'b0, 5'd6, 32'h300, 32'h0);
        tick();
        i_valid = 1'b0;
        check("rb_cmd_busy", 32'(o_bus_cmd), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rb_cmd", 32'(o_bus_cmd), 32'd0);
        check("rb_stall", 32'(o_stall), 32'd0);
        check("rb_pend", 32'(o_pend_load), 32'd0);
        check("rb_rd", 32'(o_rd), 32'd0);
        check("rb_addr", o_bus_addr, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
